// File: rtl/spi_prog_master.sv
// spi_prog_master: serialises host program/data writes and run requests onto the tiny_processor SPI-style port
module spi_prog_master #(
    parameter int GAP_CYCLES = 1,
    parameter int TIMEOUT    = 256,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [1:0]       cmd_kind_i,
    input  logic [3:0]       cmd_addr_i,
    input  logic [7:0]       cmd_data_i,
    output logic [1:0]       sel_o,
    output logic             mosi_o,
    input  logic             proc_done_i,
    output logic             busy_o,
    output logic             run_done_o,
    output logic             run_timeout_o,
    output logic [CNT_W-1:0] run_cycles_o
);
    localparam int GW = $clog2(GAP_CYCLES) + 1;
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
    typedef enum logic [1:0] {IDLE, SHIFT, GAP, RUN} state_t;
    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic             mosi_q, mosi_d;
    logic [11:0]      shreg_q, shreg_d;
    logic [3:0]       bitcnt_q, bitcnt_d;
    logic [GW-1:0]    gapcnt_q, gapcnt_d;
    logic             started_q, started_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0] run_cycles_q, run_cycles_d;
    logic             done_q, done_d, tmo_q, tmo_d;
    logic             kill;
    // the slave must never see EXEC re-entered once it reports done, so the run enable is cut combinationally
    assign kill          = (state_q == RUN) & started_q & proc_done_i;
    assign sel_o         = kill ? 2'b00 : sel_q;
    assign mosi_o        = mosi_q;
    assign cmd_ready_o   = state_q == IDLE;
    assign busy_o        = state_q != IDLE;
    assign run_done_o    = done_q;
    assign run_timeout_o = tmo_q;
    assign run_cycles_o  = run_cycles_q;
    assign cnt_inc       = &cnt_q ? cnt_q : cnt_q + 1'b1;
    // next-state and next registered-output logic
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        mosi_d       = mosi_q;
        shreg_d      = shreg_q;
        bitcnt_d     = '0;
        gapcnt_d     = '0;
        started_d    = started_q;
        cnt_d        = cnt_q;
        run_cycles_d = run_cycles_q;
        done_d       = 1'b0;
        tmo_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i && !cmd_kind_i[1]) begin
                    state_d = SHIFT;
                    sel_d   = cmd_kind_i[0] ? 2'b10 : 2'b01;
                    mosi_d  = cmd_addr_i[0];
                    shreg_d = {1'b0, cmd_data_i, cmd_addr_i[3:1]};
                end else if (cmd_valid_i && cmd_kind_i == 2'b10) begin
                    state_d   = RUN;
                    sel_d     = 2'b11;
                    started_d = 1'b0;
                    cnt_d     = '0;
                end
            end
            SHIFT: begin
                bitcnt_d = bitcnt_q + 4'd1;
                if (bitcnt_q == 4'd11) begin
                    state_d = GAP;
                    sel_d   = 2'b00;
                    mosi_d  = 1'b0;
                end else begin
                    mosi_d  = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                end
            end
            GAP: begin
                gapcnt_d = gapcnt_q + 1'b1;
                if (gapcnt_q == GW'(GAP_CYCLES - 1)) state_d = IDLE;
            end
            default: begin
                if (kill) begin
                    state_d      = GAP;
                    sel_d        = 2'b00;
                    done_d       = 1'b1;
                    run_cycles_d = cnt_q;
                end else begin
                    cnt_d = cnt_inc;
                    if (!proc_done_i) started_d = 1'b1;
                    if (cnt_inc == TMO) begin
                        state_d      = GAP;
                        sel_d        = 2'b00;
                        tmo_d        = 1'b1;
                        run_cycles_d = cnt_inc;
                    end
                end
            end
        endcase
    end
    // state and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sel_q        <= 2'b00;
            mosi_q       <= 1'b0;
            shreg_q      <= '0;
            bitcnt_q     <= '0;
            gapcnt_q     <= '0;
            started_q    <= 1'b0;
            cnt_q        <= '0;
            run_cycles_q <= '0;
            done_q       <= 1'b0;
            tmo_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            mosi_q       <= mosi_d;
            shreg_q      <= shreg_d;
            bitcnt_q     <= bitcnt_d;
            gapcnt_q     <= gapcnt_d;
            started_q    <= started_d;
            cnt_q        <= cnt_d;
            run_cycles_q <= run_cycles_d;
            done_q       <= done_d;
            tmo_q        <= tmo_d;
        end
    end
endmodule

// File: tb/tb_spi_prog_master.sv
// tb_spi_prog_master: scoreboard bench with a slave model for frames and the processor done flag
module tb_spi_prog_master;
    localparam int GAP = 1;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [1:0]  cmd_kind_i = 2'b11;
    logic [3:0]  cmd_addr_i = 4'd0;
    logic [7:0]  cmd_data_i = 8'd0;
    logic [1:0]  sel_o;
    logic        mosi_o;
    logic        proc_done_i = 1'b1;
    logic        busy_o, run_done_o, run_timeout_o;
    logic [15:0] run_cycles_o;
    int          n_chk = 0, n_fail = 0;
    logic [33:0] exp_q[$];
    logic [7:0]  icache[16];
    logic [7:0]  dmem[16];
    int          nb = 0, zcnt = 0, run11 = 0, gap_arm = 0, hold = 0;
    logic [11:0] fbits = '0;
    logic [1:0]  fsel = 2'b00;
    logic        run_arm = 1'b0;

    spi_prog_master #(.GAP_CYCLES(GAP), .TIMEOUT(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_kind_i(cmd_kind_i), .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i),
        .sel_o(sel_o), .mosi_o(mosi_o), .proc_done_i(proc_done_i), .busy_o(busy_o),
        .run_done_o(run_done_o), .run_timeout_o(run_timeout_o), .run_cycles_o(run_cycles_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [33:0] fr(input logic [1:0] s, input logic [3:0] a, input logic [7:0] d);
        return {12'd0, 8'd12, s, d, a};
    endfunction

    function automatic logic [33:0] rn(input logic dn, input logic to, input logic [15:0] c);
        return {dn, to, c, c};
    endfunction

    // processor done flag: optionally drops for 5 cycles after the first run-enable cycle
    always @(posedge clk) begin
        if (hold > 0) begin
            hold <= hold - 1;
            if (hold == 1) proc_done_i <= 1'b1;
        end else if (run_arm && proc_done_i && sel_o == 2'b11) begin
            proc_done_i <= 1'b0;
            hold <= 5;
        end
    end

    // monitor: rebuild frames / run results from the pins and compare against the scoreboard
    always @(negedge clk) begin
        if (rst) begin
            nb = 0;
            run11 = 0;
        end else begin
            if (sel_o == 2'b01 || sel_o == 2'b10) begin
                if (nb == 0) begin
                    if (gap_arm == 1) chk("gap", 34'(zcnt), 34'(GAP + 1));
                    if (gap_arm > 0) gap_arm--;
                    fsel = sel_o;
                end
                if (nb < 12) fbits[nb] = mosi_o;
                nb++;
                zcnt = 0;
            end else begin
                if (sel_o == 2'b00) zcnt++;
                if (nb != 0) begin
                    if (exp_q.size() == 0) chk("frame_unexpected", 34'(nb), 34'd0);
                    else chk("frame", {12'd0, 8'(nb), fsel, fbits}, exp_q.pop_front());
                    if (fsel == 2'b01) icache[fbits[3:0]] = fbits[11:4];
                    else dmem[fbits[3:0]] = fbits[11:4];
                    nb = 0;
                end
            end
            if (sel_o == 2'b11) run11++;
            if (run_done_o || run_timeout_o) begin
                if (exp_q.size() == 0) chk("run_unexpected", 34'(run11), 34'd0);
                else chk("run", {run_done_o, run_timeout_o, run_cycles_o, 16'(run11)}, exp_q.pop_front());
                run11 = 0;
            end
        end
    end

    // caller is at a negedge; returns at the negedge after the accept edge
    task automatic send(input logic [1:0] k, input logic [3:0] a, input logic [7:0] d);
        int i;
        cmd_kind_i = k;
        cmd_addr_i = a;
        cmd_data_i = d;
        cmd_valid_i = 1'b1;
        for (i = 0; i < 100 && !cmd_ready_o; i++) @(negedge clk);
        chk("accept", 34'(i < 100), 34'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid_i = 1'b0;
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 400 && (exp_q.size() != 0 || busy_o); i++) @(negedge clk);
        chk("drain", 34'(i < 400), 34'd1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            icache[i] = 8'h00;
            dmem[i] = 8'h00;
        end
        repeat (2) @(negedge clk);
        chk("rst_sel", 34'(sel_o), 34'd0);
        chk("rst_mosi", 34'(mosi_o), 34'd0);
        chk("rst_busy", 34'(busy_o), 34'd0);
        chk("rst_ready", 34'(cmd_ready_o), 34'd1);
        chk("rst_pulses", 34'({run_done_o, run_timeout_o}), 34'd0);
        chk("rst_cycles", 34'(run_cycles_o), 34'd0);
        #2 rst = 1'b0;
        @(negedge clk);
        exp_q.push_back(fr(2'b01, 4'd3, 8'hA5));
        send(2'b00, 4'd3, 8'hA5);
        drain();
        chk("icache3", 34'(icache[3]), 34'hA5);
        chk("ready_after", 34'(cmd_ready_o), 34'd1);
        exp_q.push_back(fr(2'b10, 4'd8, 8'h10));
        send(2'b01, 4'd8, 8'h10);
        drain();
        chk("fcnt_byte0", 34'(dmem[8]), 34'h10);
        gap_arm = 2;
        exp_q.push_back(fr(2'b01, 4'd1, 8'h3C));
        exp_q.push_back(fr(2'b10, 4'd9, 8'hC3));
        send(2'b00, 4'd1, 8'h3C);
        send(2'b01, 4'd9, 8'hC3);
        drain();
        chk("gap_checked", 34'(gap_arm), 34'd0);
        send(2'b11, 4'd2, 8'hFF);
        chk("noop_idle", 34'({busy_o, sel_o}), 34'd0);
        run_arm = 1'b1;
        exp_q.push_back(rn(1'b1, 1'b0, 16'd6));
        send(2'b10, 4'd0, 8'd0);
        drain();
        run_arm = 1'b0;
        exp_q.push_back(rn(1'b0, 1'b1, 16'd16));
        send(2'b10, 4'd0, 8'd0);
        drain();
        send(2'b00, 4'd5, 8'h77);
        repeat (5) @(negedge clk);
        chk("pre_rst_bit5", 34'({sel_o, mosi_o}), 34'b011);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_sel", 34'(sel_o), 34'd0);
        chk("rst_mid_mosi", 34'(mosi_o), 34'd0);
        chk("rst_mid_cycles", 34'(run_cycles_o), 34'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        exp_q.push_back(fr(2'b01, 4'd5, 8'h77));
        send(2'b00, 4'd5, 8'h77);
        drain();
        chk("icache5", 34'(icache[5]), 34'h77);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
